// File: rtl/spi_slave_core.sv
// SPI target core: synchronizes the bus onto clk_i, runs a single-entry tx buffer into a
// shift register and delivers received words through a valid/ready holding register.
module spi_slave_core #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic [1:0]            dtb_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_nss_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_en_o,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  ovr_o,
    output logic                  udr_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned IW = $clog2(DATA_WIDTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned SS = SYNC_STAGES;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    state_e         state_q, state_d;
    logic [SS-1:0]  sck_sync_q, sck_sync_d, nss_sync_q, nss_sync_d, mosi_sync_q, mosi_sync_d;
    logic           sck_prev_q, sck_prev_d, nss_prev_q, nss_prev_d;
    logic           cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [CW-1:0]  n_q, n_d, cnt_q, cnt_d;
    logic           skip_q, skip_d, done_q, done_d;
    logic [DW-1:0]  tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [DW-1:0]  txbuf_q, txbuf_d, rx_hold_q, rx_hold_d;
    logic           txfull_q, txfull_d, rx_valid_q, rx_valid_d, rx_pend_q, rx_pend_d;
    logic           miso_q, miso_d, ovr_q, ovr_d, udr_q, udr_d;
    logic           tx_load;

    logic           sck_s, nss_s, mosi_s, lead_edge, trail_edge, sample_edge, shift_edge;
    logic           nss_fall, nss_rise;
    logic [DW-1:0]  rx_mask, rx_word;

    assign sck_s       = sck_sync_q[SS-1];
    assign nss_s       = nss_sync_q[SS-1];
    assign mosi_s      = mosi_sync_q[SS-1];
    assign lead_edge   = (sck_s != sck_prev_q) && (sck_s != cpol_q);
    assign trail_edge  = (sck_s != sck_prev_q) && (sck_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign nss_fall    = nss_prev_q && !nss_s;
    assign nss_rise    = !nss_prev_q && nss_s;

    // Received bits sit at the top (lsb first) or bottom (msb first) of rx_sr; align to bit 0.
    assign rx_mask = (DW'(1) << n_q) - DW'(1);
    assign rx_word = lsb_q ? (rx_sr_q >> (CW'(DW) - n_q)) : (rx_sr_q & rx_mask);

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SS-2:0], spi_sck_i};
        nss_sync_d  = {nss_sync_q[SS-2:0], spi_nss_i};
        mosi_sync_d = {mosi_sync_q[SS-2:0], spi_mosi_i};
        sck_prev_d  = sck_s;
        nss_prev_d  = nss_s;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsb_d       = lsb_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        skip_d      = skip_q;
        done_d      = 1'b0;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        txbuf_d     = txbuf_q;
        txfull_d    = txfull_q;
        rx_hold_d   = rx_hold_q;
        rx_valid_d  = rx_valid_q;
        rx_pend_d   = rx_pend_q;
        ovr_d       = 1'b0;
        udr_d       = 1'b0;
        tx_load     = 1'b0;

        if (tx_valid_i && !txfull_q) begin
            txbuf_d  = tx_data_i;
            txfull_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (nss_fall && en_i) begin
                    state_d = ST_SHIFT;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    lsb_d   = lsb_i;
                    n_d     = CW'((32'(dtb_i) + 32'd1) << 3);
                    cnt_d   = '0;
                    skip_d  = cpha_i;
                    tx_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (nss_rise || !en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (shift_edge) begin
                        if (skip_q) skip_d = 1'b0;
                        else tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                    end
                    if (sample_edge) begin
                        rx_sr_d = lsb_q ? {mosi_s, rx_sr_q[DW-1:1]} : {rx_sr_q[DW-2:0], mosi_s};
                        if (cnt_q == n_q - CW'(1)) begin
                            // Word done: next word is presented on the following shift edge
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            skip_d  = 1'b1;
                            tx_load = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_load) begin
            if (txfull_q) begin
                tx_sr_d  = txbuf_q;
                txfull_d = 1'b0;
            end else begin
                tx_sr_d = '0;
                udr_d   = 1'b1;
            end
        end

        // Holding register: overrun keeps the old word, a same-cycle handshake swaps seamlessly
        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
        if (rx_pend_q) begin
            rx_valid_d = 1'b1;
            rx_pend_d  = 1'b0;
        end
        if (done_q) begin
            if (rx_valid_q && !rx_ready_i) begin
                ovr_d = 1'b1;
            end else begin
                rx_hold_d = rx_word;
                if (rx_valid_q) rx_valid_d = 1'b1;
                else rx_pend_d = 1'b1;
            end
        end

        miso_d = (state_d == ST_SHIFT) ? (lsb_d ? tx_sr_d[0] : tx_sr_d[IW'(n_d - CW'(1))]) : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            sck_sync_q  <= '0;
            nss_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            nss_prev_q  <= 1'b1;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            n_q         <= CW'(8);
            cnt_q       <= '0;
            skip_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            txbuf_q     <= '0;
            txfull_q    <= 1'b0;
            rx_hold_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_pend_q   <= 1'b0;
            miso_q      <= 1'b0;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            nss_sync_q  <= nss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            nss_prev_q  <= nss_prev_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsb_q       <= lsb_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            done_q      <= done_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            txbuf_q     <= txbuf_d;
            txfull_q    <= txfull_d;
            rx_hold_q   <= rx_hold_d;
            rx_valid_q  <= rx_valid_d;
            rx_pend_q   <= rx_pend_d;
            miso_q      <= miso_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_en_o = (state_q == ST_SHIFT);
    assign busy_o        = (state_q == ST_SHIFT);
    assign tx_ready_o    = ~txfull_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_data_o     = rx_hold_q;
    assign ovr_o         = ovr_q;
    assign udr_o         = udr_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: acts as the SPI initiator and checks against a word-level model
// of the tx buffer, the rx holding register and the overrun/underrun pulses.
module tb_spi_slave_core;

    logic        clk_i = 1'b0;
    logic        rst_n_i, en_i, cpol_i, cpha_i, lsb_i;
    logic [1:0]  dtb_i;
    logic        spi_sck_i, spi_nss_i, spi_mosi_i, spi_miso_o, spi_miso_en_o;
    logic        tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, busy_o, ovr_o, udr_o;
    logic [31:0] tx_data_i, rx_data_o;

    always #5 clk_i = ~clk_i;

    spi_slave_core #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_i(lsb_i), .dtb_i(dtb_i),
        .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
        .busy_o(busy_o), .ovr_o(ovr_o), .udr_o(udr_o)
    );

    int tests = 0, fails = 0;
    int udr_cnt = 0, ovr_cnt = 0, exp_udr = 0, exp_ovr = 0;
    logic        mon_en = 1'b0;
    logic        m_valid = 1'b0, m_txfull = 1'b0;
    logic [31:0] m_hold = '0, m_txword = '0, m_cur = '0, cap = '0;
    logic [31:0] mosi_w [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        if (udr_o) udr_cnt++;
        if (ovr_o) ovr_cnt++;
    end

    // Per-cycle compare against the model while out of reset
    always @(negedge clk_i) begin
        if (rst_n_i && mon_en) begin
            check("busy_vs_miso_en", 32'(busy_o), 32'(spi_miso_en_o));
            if (!busy_o) check("miso_idle_zero", 32'(spi_miso_o), 32'd0);
            if (rx_valid_o) begin
                check("rx_valid_model", 32'd1, 32'(m_valid));
                check("rx_data_model", rx_data_o, m_hold);
            end
        end
    end

    task automatic m_load();
        if (m_txfull) begin
            m_cur    = m_txword;
            m_txfull = 1'b0;
        end else begin
            m_cur = '0;
            exp_udr++;
        end
    endtask

    task automatic m_complete(input logic [31:0] word);
        if (m_valid) exp_ovr++;
        else begin
            m_valid = 1'b1;
            m_hold  = word;
        end
    endtask

    task automatic clr();
        udr_cnt = 0; ovr_cnt = 0; exp_udr = 0; exp_ovr = 0;
    endtask

    task automatic chk_counts(input string name);
        check({name, "_udr_count"}, 32'(udr_cnt), 32'(exp_udr));
        check({name, "_ovr_count"}, 32'(ovr_cnt), 32'(exp_ovr));
    endtask

    task automatic push(input logic [31:0] d);
        int k = 0;
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        while (!tx_ready_o && k < 64) begin
            wait_clk(1);
            k++;
        end
        check("tx_ready_wait", 32'(tx_ready_o), 32'd1);
        wait_clk(1);
        tx_valid_i = 1'b0;
        m_txfull   = 1'b1;
        m_txword   = d;
    endtask

    task automatic pop(input logic [31:0] lit);
        int k = 0;
        while (!rx_valid_o && k < 64) begin
            wait_clk(1);
            k++;
        end
        check("rx_valid_rise", 32'(rx_valid_o), 32'd1);
        check("rx_data_lit", rx_data_o, lit);
        check("model_hold_lit", m_hold, lit);
        rx_ready_i = 1'b1;
        wait_clk(1);
        rx_ready_i = 1'b0;
        m_valid    = 1'b0;
        wait_clk(1);
        check("rx_valid_drop", 32'(rx_valid_o), 32'd0);
    endtask

    task automatic sample_miso(input logic lsb, input int b);
        check("miso_bit", 32'(spi_miso_o), 32'(m_cur[b]));
        if (lsb) cap = {spi_miso_o, cap[31:1]};
        else cap = {cap[30:0], spi_miso_o};
    endtask

    // Initiator: nwords words under one NSS, the last one cut to nb_last bits
    task automatic xfer(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] dtb,
                        input int nwords, input int nb_last, input bit push2,
                        input logic [31:0] tx2, input bit raise);
        int n, nb, b;
        logic [31:0] mask;
        n    = 8 * (int'(dtb) + 1);
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        cpol_i = cpol; cpha_i = cpha; lsb_i = lsb; dtb_i = dtb;
        spi_sck_i = cpol;
        cap = '0;
        wait_clk(8);
        spi_nss_i = 1'b0;
        m_load();
        wait_clk(8);
        check("udr_at_nss_fall", 32'(udr_cnt), 32'(exp_udr));
        if (push2) push(tx2);
        for (int w = 0; w < nwords; w++) begin
            nb = (w == nwords - 1) ? nb_last : n;
            for (int i = 0; i < nb; i++) begin
                b = lsb ? i : n - 1 - i;
                if (!cpha) begin
                    spi_mosi_i = mosi_w[w][b];
                    wait_clk(8);
                    sample_miso(lsb, b);
                    spi_sck_i = ~cpol;
                    if (i == n - 1) begin m_complete(mosi_w[w] & mask); m_load(); end
                    wait_clk(8);
                    spi_sck_i = cpol;
                end else begin
                    spi_sck_i  = ~cpol;
                    spi_mosi_i = mosi_w[w][b];
                    wait_clk(8);
                    sample_miso(lsb, b);
                    spi_sck_i = cpol;
                    if (i == n - 1) begin m_complete(mosi_w[w] & mask); m_load(); end
                end
                wait_clk(8);
            end
        end
        if (raise) begin
            spi_nss_i = 1'b1;
            wait_clk(16);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_tx_ready"}, 32'(tx_ready_o), 32'd1);
        check({name, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
        check({name, "_rx_data"}, rx_data_o, 32'd0);
        check({name, "_miso"}, 32'(spi_miso_o), 32'd0);
        check({name, "_miso_en"}, 32'(spi_miso_en_o), 32'd0);
        check({name, "_busy"}, 32'(busy_o), 32'd0);
        check({name, "_ovr"}, 32'(ovr_o), 32'd0);
        check({name, "_udr"}, 32'(udr_o), 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0; en_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; dtb_i = 2'b00;
        spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
        tx_valid_i = 1'b0; tx_data_i = '0; rx_ready_i = 1'b0;
        mosi_w[0] = '0; mosi_w[1] = '0;
        wait_clk(3);
        check_reset("por");
        rst_n_i = 1'b1;
        wait_clk(3);
        en_i   = 1'b1;
        mon_en = 1'b1;

        // Mode 0, 8-bit, msb first
        clr();
        push(32'hA5);
        mosi_w[0] = 32'h3C;
        xfer(1'b0, 1'b0, 1'b0, 2'b00, 1, 8, 1'b0, '0, 1'b1);
        check("m0_miso_bits", cap & 32'hFF, 32'hA5);
        pop(32'h0000_003C);
        chk_counts("m0");

        // Mode 3, 32-bit, lsb first
        clr();
        push(32'h1234_5678);
        mosi_w[0] = 32'hDEAD_BEEF;
        xfer(1'b1, 1'b1, 1'b1, 2'b11, 1, 32, 1'b0, '0, 1'b1);
        check("m3_miso_word", cap, 32'h1234_5678);
        pop(32'hDEAD_BEEF);
        chk_counts("m3");

        // Two words under one NSS, rx not drained: second word overruns
        clr();
        push(32'h5A);
        mosi_w[0] = 32'h81;
        mosi_w[1] = 32'h7E;
        xfer(1'b0, 1'b0, 1'b0, 2'b00, 2, 8, 1'b1, 32'hC3, 1'b1);
        check("b2b_miso_words", cap & 32'hFFFF, 32'h5AC3);
        check("b2b_model_ovr", 32'(exp_ovr), 32'd1);
        chk_counts("b2b");
        pop(32'h81);
        wait_clk(8);
        check("b2b_second_dropped", 32'(rx_valid_o), 32'd0);

        // Empty tx buffer, mode 1, 16-bit
        clr();
        mosi_w[0] = 32'hBEEF;
        xfer(1'b0, 1'b1, 1'b0, 2'b01, 1, 16, 1'b0, '0, 1'b1);
        check("udr_miso_zero", cap & 32'hFFFF, 32'h0);
        pop(32'h0000_BEEF);
        chk_counts("udr");

        // Abort after 5 of 8 bits, then a clean frame
        clr();
        push(32'h3C);
        mosi_w[0] = 32'hFF;
        xfer(1'b0, 1'b0, 1'b0, 2'b00, 1, 5, 1'b0, '0, 1'b1);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_miso_en", 32'(spi_miso_en_o), 32'd0);
        check("abort_rx_valid", 32'(rx_valid_o), 32'd0);
        chk_counts("abort");
        push(32'h99);
        mosi_w[0] = 32'h42;
        xfer(1'b0, 1'b0, 1'b0, 2'b00, 1, 8, 1'b0, '0, 1'b1);
        check("after_abort_miso", cap & 32'hFF, 32'h99);
        pop(32'h42);

        // Mode 2, 24-bit, lsb first: upper tx/mosi bits never appear
        clr();
        push(32'hFFAB_CDEF);
        mosi_w[0] = 32'hFF12_3456;
        xfer(1'b1, 1'b0, 1'b1, 2'b10, 1, 24, 1'b0, '0, 1'b1);
        check("m2_miso_word", cap >> 8, 32'h00AB_CDEF);
        pop(32'h0012_3456);
        chk_counts("m2");

        // Reset asserted mid-frame with a word held
        push(32'hF0);
        mosi_w[0] = 32'h11;
        xfer(1'b0, 1'b0, 1'b0, 2'b00, 1, 8, 1'b0, '0, 1'b1);
        push(32'h0F);
        mosi_w[0] = 32'h22;
        xfer(1'b0, 1'b0, 1'b0, 2'b00, 1, 3, 1'b0, '0, 1'b0);
        wait_clk(2);
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        check("pre_reset_rx_valid", 32'(rx_valid_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        check_reset("mid_rst");
        m_valid = 1'b0; m_txfull = 1'b0;
        spi_nss_i = 1'b1; spi_sck_i = 1'b0;
        wait_clk(3);
        rst_n_i = 1'b1;
        wait_clk(4);
        clr();
        push(32'h6D);
        mosi_w[0] = 32'hB2;
        xfer(1'b0, 1'b0, 1'b0, 2'b00, 1, 8, 1'b0, '0, 1'b1);
        check("post_rst_miso", cap & 32'hFF, 32'h6D);
        pop(32'hB2);
        chk_counts("post_rst");

        mon_en = 1'b0;
        wait_clk(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
